// File: rtl/counter_4bit_if.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// counter_4bit_if
// Groups the counter's data-side signals into one bundle.
//   en    : count enable, driven by the master (the user of the counter)
//   cout  : current count value, driven by the counter
//   tc    : terminal-count flag, driven by the counter
// Modports:
//   master : drives en, observes cout/tc
//   slave  : the counter itself; observes en, drives cout/tc
// ----------------------------------------------------------------------------
interface counter_4bit_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] cout;
  logic             tc;

  modport master (output en, input cout, input tc);
  modport slave  (input en, output cout, output tc);
endinterface : counter_4bit_if

// File: rtl/counter_4bit.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// counter_4bit
// Synchronous up-counter with count enable and asynchronous active-low reset.
// Counts 0,1,...,MAXVAL,0,... on each rising clk edge while en is high and
// holds its value while en is low. The count is a register output; tc is a
// pure decode of that register, so nothing on the input side reaches an
// output without passing through a flop.
//
// Parameters:
//   WIDTH  : counter width in bits (1..32)
//   MAXVAL : terminal value, count wraps to 0 after it (defaults to all-ones)
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous reset, active low (0 clears the count immediately)
//   bus : counter_4bit_if slave modport carrying en (in), cout/tc (out)
// ----------------------------------------------------------------------------
module counter_4bit #(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] MAXVAL = {WIDTH{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  counter_4bit_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic             at_max;

  // Compare against MAXVAL instead of relying on natural binary overflow so
  // that non power-of-two terminal values (e.g. a decade counter) wrap right.
  assign at_max = (count_q == MAXVAL);

  // NOTE: the reset is in the sensitivity list so that rst falling clears the
  // count at once, without a clock edge; rst is active low, hence negedge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (bus.en) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values, independent of block evaluation order.
      count_q <= at_max ? '0 : count_q + WIDTH'(1);
    end
  end

  assign bus.cout = count_q;
  assign bus.tc   = at_max;

endmodule : counter_4bit

// File: tb/tb_counter_4bit.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_counter_4bit
// Drives a default counter (modulo 16) and a decade counter (MAXVAL=9) from a
// shared clock and reset, each with its own enable, and compares both against
// a modular-arithmetic reference model after every edge and every reset.
// ----------------------------------------------------------------------------
module tb_counter_4bit;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain integers counting modulo (MAXVAL+1).
  int m16 = 0;
  int m10 = 0;

  counter_4bit_if #(.WIDTH(4)) bus16 ();
  counter_4bit_if #(.WIDTH(4)) bus10 ();

  counter_4bit #(.WIDTH(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  counter_4bit #(.WIDTH(4), .MAXVAL(4'd9)) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (bus10)
  );

  always #2 clk = ~clk;

  // Wait for the next rising edge, advance the model, then step 1 unit away
  // from the edge so outputs are sampled and inputs driven between edges.
  task automatic advance();
    @(posedge clk);
    if (rst === 1'b1) begin
      if (bus16.en) m16 = (m16 + 1) % 16;
      if (bus10.en) m10 = (m10 + 1) % 10;
    end else begin
      m16 = 0;
      m10 = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    bus16.en  = 1'b0;
    bus10.en  = 1'b0;
    #1;
    checks++;
    if (bus16.cout !== 4'd0 || bus16.tc !== 1'b0) begin
      failures++;
      $display("FAIL reset_pre_edge16 cout=%0d tc=%b expected cout=0 tc=0", bus16.cout, bus16.tc);
    end
    checks++;
    if (bus10.cout !== 4'd0 || bus10.tc !== 1'b0) begin
      failures++;
      $display("FAIL reset_pre_edge10 cout=%0d tc=%b expected cout=0 tc=0", bus10.cout, bus10.tc);
    end
    bus16.en = 1'b1;
    bus10.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      advance();
      checks++;
      if (bus16.cout !== 4'd0 || bus16.tc !== 1'b0 || bus10.cout !== 4'd0 || bus10.tc !== 1'b0) begin
        failures++;
        $display("FAIL reset_held edge=%0d cout16=%0d tc16=%b cout10=%0d tc10=%b expected all 0",
                 i, bus16.cout, bus16.tc, bus10.cout, bus10.tc);
      end
    end
  endtask

  task automatic test_count();
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      advance();
      checks++;
      if (bus16.cout !== 4'(i) || m16 != i) begin
        failures++;
        $display("FAIL count step=%0d cout=%0d expected %0d", i, bus16.cout, i);
      end
    end
  endtask

  task automatic test_hold();
    bus16.en = 1'b0;
    bus10.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      advance();
      checks++;
      if (bus16.cout !== 4'd5 || bus10.cout !== 4'(m10)) begin
        failures++;
        $display("FAIL hold edge=%0d cout16=%0d cout10=%0d expected %0d/%0d",
                 i, bus16.cout, bus10.cout, 5, m10);
      end
    end
    bus16.en = 1'b1;
    bus10.en = 1'b1;
    advance();
    checks++;
    if (bus16.cout !== 4'd6) begin
      failures++;
      $display("FAIL resume cout=%0d expected 6", bus16.cout);
    end
  endtask

  task automatic test_wrap();
    // Clear asynchronously mid-cycle, then count 16 edges from zero.
    rst = 1'b0;
    m16 = 0;
    m10 = 0;
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      advance();
      checks++;
      if (bus16.cout !== 4'(m16) || bus16.tc !== (m16 == 15)) begin
        failures++;
        $display("FAIL wrap16 step=%0d cout=%0d tc=%b expected cout=%0d tc=%b",
                 i, bus16.cout, bus16.tc, m16, (m16 == 15));
      end
      checks++;
      if (bus10.cout !== 4'(m10) || bus10.tc !== (m10 == 9)) begin
        failures++;
        $display("FAIL wrap10 step=%0d cout=%0d tc=%b expected cout=%0d tc=%b",
                 i, bus10.cout, bus10.tc, m10, (m10 == 9));
      end
    end
    // After 16 edges from 0 the modulo-16 counter is back at 0.
    checks++;
    if (bus16.cout !== 4'd0 || bus16.tc !== 1'b0) begin
      failures++;
      $display("FAIL wrap16_end cout=%0d tc=%b expected cout=0 tc=0", bus16.cout, bus16.tc);
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b0;
    m16 = 0;
    m10 = 0;
    #1;
    rst = 1'b1;
    for (int i = 0; i < 9; i++) advance();
    checks++;
    if (bus16.cout !== 4'd9 || bus10.cout !== 4'd9 || bus10.tc !== 1'b1 || bus16.tc !== 1'b0) begin
      failures++;
      $display("FAIL reach9 cout16=%0d tc16=%b cout10=%0d tc10=%b expected 9/0/9/1",
               bus16.cout, bus16.tc, bus10.cout, bus10.tc);
    end
    #0.5;
    rst = 1'b0;
    m16 = 0;
    m10 = 0;
    #0.5;
    checks++;
    if (bus16.cout !== 4'd0 || bus16.tc !== 1'b0 || bus10.cout !== 4'd0 || bus10.tc !== 1'b0) begin
      failures++;
      $display("FAIL async_clear cout16=%0d tc16=%b cout10=%0d tc10=%b expected all 0",
               bus16.cout, bus16.tc, bus10.cout, bus10.tc);
    end
    for (int i = 0; i < 3; i++) begin
      advance();
      checks++;
      if (bus16.cout !== 4'd0 || bus10.cout !== 4'd0) begin
        failures++;
        $display("FAIL reset_with_en edge=%0d cout16=%0d cout10=%0d expected 0", i, bus16.cout, bus10.cout);
      end
    end
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      advance();
      checks++;
      if (bus16.cout !== 4'(i) || bus10.cout !== 4'(i)) begin
        failures++;
        $display("FAIL restart step=%0d cout16=%0d cout10=%0d expected %0d", i, bus16.cout, bus10.cout, i);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus16.en = 1'($urandom_range(0, 3) != 0);
      bus10.en = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        #0.5;
        rst = 1'b0;
        m16 = 0;
        m10 = 0;
        #0.5;
        checks++;
        if (bus16.cout !== 4'd0 || bus10.cout !== 4'd0) begin
          failures++;
          $display("FAIL rand_async iter=%0d cout16=%0d cout10=%0d expected 0", i, bus16.cout, bus10.cout);
        end
      end else begin
        rst = 1'b1;
      end
      advance();
      checks++;
      if (bus16.cout !== 4'(m16) || bus16.tc !== (m16 == 15) ||
          bus10.cout !== 4'(m10) || bus10.tc !== (m10 == 9)) begin
        failures++;
        $display("FAIL rand iter=%0d cout16=%0d tc16=%b cout10=%0d tc10=%b expected %0d/%b/%0d/%b",
                 i, bus16.cout, bus16.tc, bus10.cout, bus10.tc, m16, (m16 == 15), m10, (m10 == 9));
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_counter_4bit
